// File: rtl/exmem_latch_if.sv
// EX/MEM latch bus: EX-stage inputs, pipeline control, latched outputs,
// the data-memory request and a debug view of the request FSM state.
//
// Handshake: the latch raises dmemREN or dmemWEN while a request is
// outstanding and holds the address and store data stable until the
// memory answers with a one-cycle dhit. The request drops on the first
// edge after dhit and is never reissued for the same instruction.
interface exmem_latch_if;
    // pipeline control
    logic        ihit;
    logic        dhit;
    logic        flush;
    // EX stage values
    logic [31:0] ex_port_o;
    logic [31:0] ex_rdat2;
    logic [4:0]  ex_wsel;
    logic        ex_WEN;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic        ex_MemToReg;
    logic        ex_halt;
    // latched values
    logic [31:0] exmem_port_o;
    logic [4:0]  exmem_wsel;
    logic        exmem_WEN;
    logic        exmem_MemToReg;
    logic        exmem_halt;
    // data-memory request
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        exmem_stall;
    // debug: request FSM state (0 IDLE, 1 ACCESS, 2 DONE)
    logic [1:0]  exmem_state;

    modport slave (
        input  ihit, dhit, flush,
        input  ex_port_o, ex_rdat2, ex_wsel, ex_WEN, ex_dREN, ex_dWEN,
        input  ex_MemToReg, ex_halt,
        output exmem_port_o, exmem_wsel, exmem_WEN, exmem_MemToReg, exmem_halt,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, exmem_stall,
        output exmem_state
    );

    modport master (
        output ihit, dhit, flush,
        output ex_port_o, ex_rdat2, ex_wsel, ex_WEN, ex_dREN, ex_dWEN,
        output ex_MemToReg, ex_halt,
        input  exmem_port_o, exmem_wsel, exmem_WEN, exmem_MemToReg, exmem_halt,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, exmem_stall,
        input  exmem_state
    );
endinterface

// File: rtl/exmem_latch.sv
// EX/MEM pipeline register with data-memory request FSM.
// Captures EX results on advance, issues the load/store request, and stalls
// the front of the pipeline until the memory access completes. A latched
// HALT freezes everything until reset.
module exmem_latch (
    input  logic          CLK,
    input  logic          nRST,
    exmem_latch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] port_q,  port_d;
    logic [31:0] rdat2_q, rdat2_d;
    logic [4:0]  wsel_q,  wsel_d;
    logic        wen_q,   wen_d;
    logic        dren_q,  dren_d;
    logic        dwen_q,  dwen_d;
    logic        m2r_q,   m2r_d;
    logic        halt_q,  halt_d;

    logic in_access;
    logic advance;

    assign in_access = (state_q == ACCESS);
    // Advance needs the fetch done, no outstanding access (or it finishes
    // now), and no latched halt.
    assign advance   = bus.ihit & (~in_access | bus.dhit) & ~halt_q;

    // State and field registers; async reset clears the request at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            port_q  <= 32'h0;
            rdat2_q <= 32'h0;
            wsel_q  <= 5'd0;
            wen_q   <= 1'b0;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            m2r_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            rdat2_q <= rdat2_d;
            wsel_q  <= wsel_d;
            wen_q   <= wen_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            m2r_q   <= m2r_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state and field capture: bubble on flush, capture on advance,
    // move to DONE when the access ends without an advance.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        rdat2_d = rdat2_q;
        wsel_d  = wsel_q;
        wen_d   = wen_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        m2r_d   = m2r_q;
        halt_d  = halt_q;

        if (advance) begin
            if (bus.flush) begin
                state_d = IDLE;
                port_d  = 32'h0;
                rdat2_d = 32'h0;
                wsel_d  = 5'd0;
                wen_d   = 1'b0;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
                m2r_d   = 1'b0;
                halt_d  = 1'b0;
            end else begin
                state_d = (bus.ex_dREN | bus.ex_dWEN) ? ACCESS : IDLE;
                port_d  = bus.ex_port_o;
                rdat2_d = bus.ex_rdat2;
                wsel_d  = bus.ex_wsel;
                wen_d   = bus.ex_WEN;
                dren_d  = bus.ex_dREN;
                dwen_d  = bus.ex_dWEN;
                m2r_d   = bus.ex_MemToReg;
                halt_d  = bus.ex_halt;
            end
        end else if (in_access && bus.dhit && !halt_q) begin
            state_d = DONE;
        end
    end

    assign bus.exmem_port_o   = port_q;
    assign bus.exmem_wsel     = wsel_q;
    assign bus.exmem_WEN      = wen_q;
    assign bus.exmem_MemToReg = m2r_q;
    assign bus.exmem_halt     = halt_q;
    assign bus.dmemaddr       = port_q;
    assign bus.dmemstore      = rdat2_q;
    // A store wins over a simultaneous (illegal) load request.
    assign bus.dmemWEN        = in_access & dwen_q;
    assign bus.dmemREN        = in_access & dren_q & ~dwen_q;
    assign bus.exmem_stall    = in_access & ~bus.dhit & ~halt_q;
    assign bus.exmem_state    = state_q;

endmodule

// File: tb/tb_exmem_latch.sv
// Directed bench for exmem_latch: a vector table for single-edge behaviour
// plus hand-written sequences for load latency, flush during access,
// asynchronous reset mid-access and halt freeze.
module tb_exmem_latch;

    logic clk;
    logic nrst;
    int   tests;
    int   fails;

    exmem_latch_if bus ();

    exmem_latch dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    typedef struct {
        logic        flush, ihit, dhit;
        logic [31:0] port, rdat2;
        logic [4:0]  wsel;
        logic        wen, dren, dwen, m2r;
        logic [31:0] e_port;
        logic [4:0]  e_wsel;
        logic        e_wen, e_m2r;
        logic [31:0] e_store;
        logic        e_ren, e_dwen, e_stall;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[13];

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ihit        = 1'b0;
        bus.dhit        = 1'b0;
        bus.flush       = 1'b0;
        bus.ex_port_o   = 32'h0;
        bus.ex_rdat2    = 32'h0;
        bus.ex_wsel     = 5'd0;
        bus.ex_WEN      = 1'b0;
        bus.ex_dREN     = 1'b0;
        bus.ex_dWEN     = 1'b0;
        bus.ex_MemToReg = 1'b0;
        bus.ex_halt     = 1'b0;
    endtask

    task automatic set_ex(input logic [31:0] port, input logic [31:0] rdat2,
                          input logic [4:0] wsel, input logic wen,
                          input logic dren, input logic dwen, input logic m2r,
                          input logic halt);
        bus.ex_port_o   = port;
        bus.ex_rdat2    = rdat2;
        bus.ex_wsel     = wsel;
        bus.ex_WEN      = wen;
        bus.ex_dREN     = dren;
        bus.ex_dWEN     = dwen;
        bus.ex_MemToReg = m2r;
        bus.ex_halt     = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " port"},  bus.exmem_port_o, 32'h0);
        check({tag, " wsel"},  32'(bus.exmem_wsel), 32'h0);
        check({tag, " wen"},   32'(bus.exmem_WEN), 32'h0);
        check({tag, " m2r"},   32'(bus.exmem_MemToReg), 32'h0);
        check({tag, " halt"},  32'(bus.exmem_halt), 32'h0);
        check({tag, " ren"},   32'(bus.dmemREN), 32'h0);
        check({tag, " dwen"},  32'(bus.dmemWEN), 32'h0);
        check({tag, " addr"},  bus.dmemaddr, 32'h0);
        check({tag, " store"}, bus.dmemstore, 32'h0);
        check({tag, " stall"}, 32'(bus.exmem_stall), 32'h0);
        check({tag, " state"}, 32'(bus.exmem_state), 32'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //                flush ihit dhit port          rdat2         wsel  wen dren dwen m2r | e_port       e_wsel e_wen e_m2r e_store      ren dwen stall state
        vecs[0]  = '{N, Y, N, 32'h1234, 32'h0,        5'd5,  Y, N, N, N, 32'h1234, 5'd5,  Y, N, 32'h0,        N, N, N, 2'd0};
        vecs[1]  = '{N, N, N, 32'h9999, 32'h0,        5'd7,  Y, N, N, N, 32'h1234, 5'd5,  Y, N, 32'h0,        N, N, N, 2'd0};
        vecs[2]  = '{N, Y, N, 32'hABCD, 32'h0,        5'd31, N, N, N, N, 32'hABCD, 5'd31, N, N, 32'h0,        N, N, N, 2'd0};
        vecs[3]  = '{Y, Y, N, 32'h5555, 32'h0,        5'd3,  Y, N, N, N, 32'h0,    5'd0,  N, N, 32'h0,        N, N, N, 2'd0};
        vecs[4]  = '{N, Y, N, 32'h40,   32'h0,        5'd8,  Y, Y, N, Y, 32'h40,   5'd8,  Y, Y, 32'h0,        Y, N, Y, 2'd1};
        vecs[5]  = '{N, Y, N, 32'h77,   32'h0,        5'd9,  Y, N, N, N, 32'h40,   5'd8,  Y, Y, 32'h0,        Y, N, Y, 2'd1};
        vecs[6]  = '{N, Y, Y, 32'h88,   32'h0,        5'd9,  Y, N, N, N, 32'h88,   5'd9,  Y, N, 32'h0,        N, N, N, 2'd0};
        vecs[7]  = '{N, Y, N, 32'h100,  32'hDEADBEEF, 5'd0,  N, N, Y, N, 32'h100,  5'd0,  N, N, 32'hDEADBEEF, N, Y, Y, 2'd1};
        vecs[8]  = '{N, N, Y, 32'h0,    32'h0,        5'd0,  N, N, N, N, 32'h100,  5'd0,  N, N, 32'hDEADBEEF, N, N, N, 2'd2};
        vecs[9]  = '{N, N, Y, 32'h0,    32'h0,        5'd0,  N, N, N, N, 32'h100,  5'd0,  N, N, 32'hDEADBEEF, N, N, N, 2'd2};
        vecs[10] = '{N, Y, N, 32'h200,  32'h0,        5'd2,  Y, N, N, N, 32'h200,  5'd2,  Y, N, 32'h0,        N, N, N, 2'd0};
        vecs[11] = '{N, Y, N, 32'h300,  32'h11,       5'd0,  N, Y, Y, N, 32'h300,  5'd0,  N, N, 32'h11,       N, Y, Y, 2'd1};
        vecs[12] = '{Y, Y, Y, 32'h999,  32'h0,        5'd1,  Y, N, N, N, 32'h0,    5'd0,  N, N, 32'h0,        N, N, N, 2'd0};

        // reset
        clear_inputs();
        nrst = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // table: drive, one edge, drop ihit/dhit/flush, then compare
        for (int i = 0; i < 13; i++) begin
            bus.flush = vecs[i].flush;
            bus.ihit  = vecs[i].ihit;
            bus.dhit  = vecs[i].dhit;
            set_ex(vecs[i].port, vecs[i].rdat2, vecs[i].wsel, vecs[i].wen,
                   vecs[i].dren, vecs[i].dwen, vecs[i].m2r, 1'b0);
            tick();
            bus.ihit  = 1'b0;
            bus.dhit  = 1'b0;
            bus.flush = 1'b0;
            #1;
            check($sformatf("r%0d port", i),  bus.exmem_port_o, vecs[i].e_port);
            check($sformatf("r%0d addr", i),  bus.dmemaddr, vecs[i].e_port);
            check($sformatf("r%0d wsel", i),  32'(bus.exmem_wsel), 32'(vecs[i].e_wsel));
            check($sformatf("r%0d wen", i),   32'(bus.exmem_WEN), 32'(vecs[i].e_wen));
            check($sformatf("r%0d m2r", i),   32'(bus.exmem_MemToReg), 32'(vecs[i].e_m2r));
            check($sformatf("r%0d store", i), bus.dmemstore, vecs[i].e_store);
            check($sformatf("r%0d ren", i),   32'(bus.dmemREN), 32'(vecs[i].e_ren));
            check($sformatf("r%0d dwen", i),  32'(bus.dmemWEN), 32'(vecs[i].e_dwen));
            check($sformatf("r%0d stall", i), 32'(bus.exmem_stall), 32'(vecs[i].e_stall));
            check($sformatf("r%0d state", i), 32'(bus.exmem_state), 32'(vecs[i].e_state));
        end

        // load with dhit in the third cycle, ihit held high throughout
        clear_inputs();
        bus.ihit = 1'b1;
        set_ex(32'h40, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_ex(32'h500, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("ld c1 ren",   32'(bus.dmemREN), 32'h1);
        check("ld c1 addr",  bus.dmemaddr, 32'h40);
        check("ld c1 stall", 32'(bus.exmem_stall), 32'h1);
        tick();
        check("ld c2 ren",   32'(bus.dmemREN), 32'h1);
        check("ld c2 stall", 32'(bus.exmem_stall), 32'h1);
        check("ld c2 wsel",  32'(bus.exmem_wsel), 32'd10);
        tick();
        bus.dhit = 1'b1;
        #1;
        check("ld c3 stall", 32'(bus.exmem_stall), 32'h0);
        check("ld c3 ren",   32'(bus.dmemREN), 32'h1);
        tick();
        bus.dhit = 1'b0;
        bus.ihit = 1'b0;
        #1;
        check("ld next port",  bus.exmem_port_o, 32'h500);
        check("ld next wsel",  32'(bus.exmem_wsel), 32'd11);
        check("ld next ren",   32'(bus.dmemREN), 32'h0);
        check("ld next state", 32'(bus.exmem_state), 32'h0);

        // flush while a load is outstanding
        clear_inputs();
        bus.ihit = 1'b1;
        set_ex(32'h80, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_ex(32'h90, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        tick();
        check("fl hold ren",   32'(bus.dmemREN), 32'h1);
        check("fl hold port",  bus.exmem_port_o, 32'h80);
        check("fl hold stall", 32'(bus.exmem_stall), 32'h1);
        bus.dhit = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("fl bubble port",  bus.exmem_port_o, 32'h0);
        check("fl bubble wsel",  32'(bus.exmem_wsel), 32'h0);
        check("fl bubble wen",   32'(bus.exmem_WEN), 32'h0);
        check("fl bubble ren",   32'(bus.dmemREN), 32'h0);
        check("fl bubble state", 32'(bus.exmem_state), 32'h0);

        // asynchronous reset while a load request is up
        bus.ihit = 1'b1;
        set_ex(32'hC0, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        clear_inputs();
        #2;
        check("rst pre ren", 32'(bus.dmemREN), 32'h1);
        nrst = 1'b0;
        #1;
        check_all_zero("rst mid");
        @(negedge clk);
        nrst = 1'b1;

        // halt freezes the latch until reset
        @(posedge clk);
        #1;
        bus.ihit = 1'b1;
        set_ex(32'h600, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("halt set",  32'(bus.exmem_halt), 32'h1);
        check("halt port", bus.exmem_port_o, 32'h600);
        bus.flush = 1'b1;
        bus.dhit  = 1'b1;
        set_ex(32'h700, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("halt frz%0d port", k),  bus.exmem_port_o, 32'h600);
            check($sformatf("halt frz%0d wsel", k),  32'(bus.exmem_wsel), 32'd4);
            check($sformatf("halt frz%0d halt", k),  32'(bus.exmem_halt), 32'h1);
            check($sformatf("halt frz%0d stall", k), 32'(bus.exmem_stall), 32'h0);
            check($sformatf("halt frz%0d ren", k),   32'(bus.dmemREN), 32'h0);
        end
        clear_inputs();
        nrst = 1'b0;
        #1;
        check_all_zero("halt rst");
        @(negedge clk);
        nrst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exmem_latch.md
# exmem_latch

EX/MEM pipeline register for the five-stage MIPS datapath, directly downstream of the EX stage. It captures the ALU result and control from EX, and drives the data-memory request with a REN/WEN handshake. It stalls the upstream pipeline while a load or store is outstanding. Its registered outputs (exmem_WEN, exmem_wsel, exmem_port_o) are the EX/MEM forwarding sources consumed by the hazard/forwarding unit.

## Interface
- No parameters. Data width is fixed at 32 bits (word_t), and register selects at 5 bits (regbits_t).
- CLK  in  1  system clock; all state is updated on the rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch complete; the pipeline may advance
- dhit  in  1  data-memory access complete
- flush  in  1  squash the instruction currently in EX; a bubble is loaded instead
- ex_port_o  in  32  ALU result (address for loads and stores)
- ex_rdat2  in  32  forwarded rt value (store data)
- ex_wsel  in  5  destination register
- ex_WEN  in  1  register-file write enable
- ex_dREN  in  1  instruction is a load
- ex_dWEN  in  1  instruction is a store
- ex_MemToReg  in  1  writeback selects memory data
- ex_halt  in  1  HALT instruction
- exmem_port_o  out  32  latched ALU result
- exmem_wsel  out  5  latched destination register
- exmem_WEN  out  1  latched write enable
- exmem_MemToReg  out  1  latched writeback select
- exmem_halt  out  1  latched halt
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- dmemaddr  out  32  equals exmem_port_o
- dmemstore  out  32  latched store data
- exmem_stall  out  1  hold PC, IF/ID and ID/EX this cycle

## Operation
- Request FSM states:
  - IDLE: no memory operation is pending.
  - ACCESS: a request is outstanding.
  - DONE: the access is complete and the latch is waiting for ihit.
- `advance = ihit & (state != ACCESS | dhit) & ~exmem_halt`
- On advance with flush=1: every latched field is loaded as 0, and the next state is IDLE.
- On advance with flush=0: every field is loaded from its ex_* input. The next state is ACCESS if ex_dREN or ex_dWEN is set, otherwise IDLE.
- No advance, state ACCESS, dhit=1: the next state is DONE and all fields hold.
- No advance in any other case: all fields and the state hold.
- Request outputs:
  - dmemREN = (state==ACCESS) & latched dREN.
  - dmemWEN = (state==ACCESS) & latched dWEN.
  - Both deassert on the first edge after dhit, so a request is never reissued.
- If latched dREN and dWEN are both 1 (illegal), dmemWEN wins and dmemREN is forced to 0.
- `exmem_stall = (state==ACCESS) & ~dhit`
- dhit while in IDLE or DONE is ignored.
- A flush during ACCESS does not abort the memory access. It is applied on the advance that ends it.
- Once exmem_halt=1 the register freezes, and exmem_stall stays 0, until reset.

## Timing
- Reset (nRST low, asynchronous):
  - All outputs are 0 and the state is IDLE.
  - Reset mid-ACCESS drops the request immediately, without waiting for a clock edge.
- Latency: an EX value appears on exmem_* on the edge after it is presented with advance=1, i.e. one cycle.
- Non-memory instructions: one per ihit edge, and exmem_stall is never asserted.
- Memory instructions:
  - The request is visible in the cycle after capture.
  - Stall is asserted from that cycle until the dhit cycle, exclusive of the dhit cycle.
  - If dhit and ihit coincide, the next instruction is captured on that same edge.
- exmem_stall is combinational from registered state and dhit; there is no path from ihit or flush.

## Test plan
- Reset mid-ACCESS: nRST low asynchronously while dmemREN=1 -> dmemREN and all outputs are 0 before the next edge, and the state is IDLE.
- ALU op: ex_port_o=0x1234, ex_wsel=5, ex_WEN=1, ihit=1 -> the next cycle shows exmem_port_o=0x1234, exmem_wsel=5, exmem_WEN=1, with dmemREN=dmemWEN=exmem_stall=0.
- Load with 3-cycle latency: ex_dREN=1, ex_port_o=0x40 captured, ihit held at 1 -> the next cycles show dmemREN=1, dmemaddr=0x40, exmem_stall=1, and fields hold. dhit arrives in cycle 3 -> stall=0 in that cycle, the next EX instruction is captured on that edge, and dmemREN=0 afterwards.
- Store, dhit before ihit: ex_dWEN=1, ex_rdat2=0xDEADBEEF -> dmemWEN=1 with dmemstore=0xDEADBEEF. dhit with ihit=0 -> the state is DONE, dmemWEN=0, stall=0, and fields hold until ihit.
- Flush during ACCESS: flush=1 asserted while a load is outstanding -> the request persists. On dhit&ihit a bubble is loaded (exmem_WEN=0, exmem_wsel=0, exmem_port_o=0).
- Halt: ex_halt=1 captured -> exmem_halt=1. Further ihit, flush or dhit leave all outputs unchanged until nRST.
